// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave): one outstanding request at a time.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests and
// redirects on branches. Define IF_FETCH_BYPASS_EN for the imem_rdata -> output bypass.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | after reset, no request outstanding
// S_FETCH | request to pc_reg_q outstanding
// S_HOLD  | fetched word buffered and presented, waiting for the pipeline
// S_DRAIN | stale request to drain_addr_q outstanding, response will be dropped
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   ready,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_addr,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            pc,
    output logic [31:0]            instruction,
    output logic                   fetch_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_reg_q;
    logic [31:0] buf_q;
    logic [31:0] buf_pc_q;
    logic [31:0] drain_addr_q;

    logic        adv;
    logic        br;
    logic [31:0] br_target;
    logic [31:0] pc_next_seq;

    assign adv         = ~freeze & ready;
    assign br          = branch_taken & ready;
    assign br_target   = {branch_addr[31:2], 2'b00};
    assign pc_next_seq = pc_reg_q + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_reg_q     <= {RESET_PC[31:2], 2'b00};
            buf_q        <= '0;
            buf_pc_q     <= '0;
            drain_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (br) begin
                        pc_reg_q <= br_target;
                    end
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (br) begin
                        pc_reg_q <= br_target;
                        // A request still in flight must be completed before
                        // the redirected one can be issued.
                        if (imem.imem_valid) begin
                            state_q <= S_FETCH;
                        end else begin
                            drain_addr_q <= pc_reg_q;
                            state_q      <= S_DRAIN;
                        end
                    end else if (imem.imem_valid) begin
`ifdef IF_FETCH_BYPASS_EN
                        if (adv) begin
                            pc_reg_q <= pc_next_seq;
                            state_q  <= S_FETCH;
                        end else begin
                            buf_q    <= imem.imem_rdata;
                            buf_pc_q <= pc_next_seq;
                            state_q  <= S_HOLD;
                        end
`else
                        buf_q    <= imem.imem_rdata;
                        buf_pc_q <= pc_next_seq;
                        state_q  <= S_HOLD;
`endif
                    end
                end
                S_HOLD: begin
                    if (br) begin
                        pc_reg_q <= br_target;
                        state_q  <= S_FETCH;
                    end else if (adv) begin
                        pc_reg_q <= pc_next_seq;
                        state_q  <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (br) begin
                        pc_reg_q <= br_target;
                    end
                    if (imem.imem_valid) begin
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bubble outputs are all-zero so they match the IF/ID flush value.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = '0;
        fetch_valid    = 1'b0;
        pc             = '0;
        instruction    = '0;
        case (state_q)
            S_FETCH: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = pc_reg_q;
`ifdef IF_FETCH_BYPASS_EN
                if (imem.imem_valid && !br) begin
                    fetch_valid = 1'b1;
                    pc          = pc_next_seq;
                    instruction = imem.imem_rdata;
                end
`endif
            end
            S_HOLD: begin
                fetch_valid = 1'b1;
                pc          = buf_pc_q;
                instruction = buf_q;
            end
            S_DRAIN: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = drain_addr_q;
            end
            default: begin
                imem.imem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected (pc, instruction) pairs follow
// program order from the reset PC or the latest accepted branch target.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_FETCH_BYPASS_EN
    localparam int THRU_EXP = 20;
`else
    localparam int THRU_EXP = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        ready = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        fetch_valid;

    if_fetch_stage_if bus();

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .ready        (ready),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (bus),
        .pc           (pc),
        .instruction  (instruction),
        .fetch_valid  (fetch_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] nxt_addr;
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cons_cnt = 0;
    int unsigned lat_max = 3;

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hE3A0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc    = nxt_addr + 32'd4;
            e.instr = mem_word(nxt_addr);
            exp_q.push_back(e);
            nxt_addr = nxt_addr + 32'd4;
        end
    endtask

    task automatic redirect(input logic [31:0] a);
        exp_q.delete();
        nxt_addr = {a[31:2], 2'b00};
        push_expected();
    endtask

    // Inputs change at negedge+1; the scoreboard is updated at negedge+3.
    task automatic drive_cycle(input logic f, input logic r, input logic bt,
                               input logic [31:0] ba, input logic rv);
        @(negedge clk);
        #1;
        freeze       = f;
        ready        = r;
        branch_taken = bt;
        branch_addr  = ba;
        rst          = rv;
        #2;
        if (!rst) redirect(RESET_PC);
        else if (branch_taken && ready) redirect(branch_addr);
        else push_expected();
    endtask

    task automatic wait_valid(input string name, input logic f);
        int n;
        n = 0;
        while (!fetch_valid && n < 20) begin
            drive_cycle(f, 1'b1, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check(name, {63'b0, fetch_valid}, 64'd1);
    endtask

    // Instruction memory: random latency, checks the request is held stable.
    initial begin : memory
        logic        pending;
        logic [31:0] m_addr;
        int unsigned m_wait;
        pending = 1'b0;
        m_addr  = '0;
        m_wait  = 0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.imem_valid = 1'b0;
            bus.imem_rdata = $urandom;
            if (!rst) begin
                pending = 1'b0;
            end else begin
                if (!pending && bus.imem_req) begin
                    pending = 1'b1;
                    m_addr  = bus.imem_addr;
                    m_wait  = $urandom_range(0, lat_max);
                end
                if (pending) begin
                    check("req_stable", {31'b0, bus.imem_req, bus.imem_addr}, {32'd1, m_addr});
                    if (m_wait == 0) begin
                        bus.imem_valid = 1'b1;
                        bus.imem_rdata = mem_word(m_addr);
                        pending        = 1'b0;
                    end else begin
                        m_wait--;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever IF/ID would capture a real instruction.
    initial begin : monitor
        logic        hold_prev;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        logic        adv;
        logic        brv;
        exp_t        e;
        hold_prev  = 1'b0;
        prev_pc    = '0;
        prev_instr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("rst_pc_instr", {pc, instruction}, 64'd0);
                check("rst_valid_req", {62'b0, fetch_valid, bus.imem_req}, 64'd0);
                hold_prev = 1'b0;
            end else begin
                adv = !freeze && ready;
                brv = branch_taken && ready;
                if (hold_prev) begin
                    check("hold_valid", {63'b0, fetch_valid}, 64'd1);
                    check("hold_data", {pc, instruction}, {prev_pc, prev_instr});
                end
                if (!fetch_valid) begin
                    check("bubble", {pc, instruction}, 64'd0);
                end else if (adv && !brv) begin
                    if (exp_q.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL fetch_out: got %h with empty scoreboard", {pc, instruction});
                    end else begin
                        e = exp_q.pop_front();
                        check("fetch_out", {pc, instruction}, {e.pc, e.instr});
                    end
                    cons_cnt++;
                end
                hold_prev  = fetch_valid && !adv && !brv;
                prev_pc    = pc;
                prev_instr = instruction;
            end
        end
    end

    initial begin : stimulus
        logic [31:0] held;
        int          c0;
        int          n;
        int          rst_cnt;
        logic [31:0] ba;
        redirect(RESET_PC);
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

        // Reset release and first fetch.
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("idle_no_req", {63'b0, bus.imem_req}, 64'd0);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("first_req", {31'b0, bus.imem_req, bus.imem_addr}, {32'd1, RESET_PC});
        n = 0;
        while (cons_cnt == 0 && n < 20) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check("first_consume", {63'b0, cons_cnt > 0}, 64'd1);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("second_req", {31'b0, bus.imem_req, bus.imem_addr}, {32'd1, RESET_PC + 32'd4});

        // Freeze hold for 5 cycles, then release.
        wait_valid("freeze_wait", 1'b1);
        held = pc;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            check("freeze_no_req", {63'b0, bus.imem_req}, 64'd0);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("addr_after_freeze", {31'b0, bus.imem_req, bus.imem_addr}, {32'd1, held});

        // Branch while ready=0 is ignored until ready returns.
        wait_valid("rdy_wait", 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h203, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("branch_req", {31'b0, bus.imem_req, bus.imem_addr}, {32'd1, 32'h200});

        // Wrap-around through 0xFFFF_FFFC.
        drive_cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (16) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        // Throughput with zero-wait memory.
        lat_max = 0;
        n = 0;
        c0 = cons_cnt;
        while (cons_cnt == c0 && n < 20) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            n++;
        end
        c0 = cons_cnt;
        repeat (20) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("throughput", 64'(cons_cnt - c0), 64'(THRU_EXP));

        // Randomised traffic with occasional mid-run resets.
        lat_max = 3;
        rst_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rst_cnt == 0 && $urandom_range(0, 399) == 0) rst_cnt = 2;
            case ($urandom_range(0, 3))
                0:       ba = $urandom;
                1:       ba = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                2:       ba = 32'($urandom_range(0, 255));
                default: ba = $urandom;
            endcase
            drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                        $urandom_range(0, 9) == 0, ba, rst_cnt == 0);
            if (rst_cnt > 0) rst_cnt--;
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
